trap_sequencer: RTL and testbench

//  Sequences machine-mode trap entry and MRET return around the CSR/exception unit.

---
 rtl/trap_pkg.sv | 35 +++
 rtl/trap_sequencer_if.sv | 55 +++++
 rtl/trap_cause_prio.sv | 44 ++++
 rtl/trap_sequencer.sv | 141 ++++++++++++++
 tb/tb_trap_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// ============================================================================
// Module      : trap_pkg
// Description : State encodings, mcause codes and helpers for trap_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_MRET_RET = 3'd5
  } trap_state_e;

  localparam logic [3:0] CAUSE_IF_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_M_EXT_IRQ   = 4'd11;

  // Interrupt causes carry the mcause interrupt bit; exceptions are zero-extended.
  function automatic logic [31:0] mcause_of(input logic [3:0] code);
    if (code == CAUSE_M_EXT_IRQ) begin
      return {1'b1, 27'd0, code};
    end
    return {28'd0, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_sequencer_if.sv
// ============================================================================
// Module      : trap_sequencer_if
// Description : Pipeline/CSR-side signal bundle of trap_sequencer.
//               irq_ext/mie_in exist only when TRAP_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_sequencer_if;
  logic        xb_illegal_csr;
  logic        fd_if_misalign;
  logic        fd_illegal;
  logic        fd_ld_misalign;
  logic        fd_st_misalign;
  logic        exc_bubble;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic [31:0] mepc_in;
`ifdef TRAP_IRQ_EN
  logic        irq_ext;
  logic        mie_in;
`endif
  logic        stall;
  logic        flush;
  logic        csr_trap_we;
  logic [31:0] csr_mepc_wd;
  logic [31:0] csr_mcause_wd;
  logic [31:0] csr_mtval_wd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_taken;

  modport master (
`ifdef TRAP_IRQ_EN
    output irq_ext, mie_in,
`endif
    output xb_illegal_csr, fd_if_misalign, fd_illegal, fd_ld_misalign, fd_st_misalign,
    output exc_bubble, exc_pc, exc_tval, mret, mepc_in,
    input  stall, flush, csr_trap_we, csr_mepc_wd, csr_mcause_wd, csr_mtval_wd,
    input  redirect_valid, redirect_pc, trap_taken
  );

  modport slave (
`ifdef TRAP_IRQ_EN
    input  irq_ext, mie_in,
`endif
    input  xb_illegal_csr, fd_if_misalign, fd_illegal, fd_ld_misalign, fd_st_misalign,
    input  exc_bubble, exc_pc, exc_tval, mret, mepc_in,
    output stall, flush, csr_trap_we, csr_mepc_wd, csr_mcause_wd, csr_mtval_wd,
    output redirect_valid, redirect_pc, trap_taken
  );
endinterface

`default_nettype wire

// File: rtl/trap_cause_prio.sv
// ============================================================================
// Module      : trap_cause_prio
// Description : Combinational priority encoder from trap flags to {valid, code}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_cause_prio
  import trap_pkg::*;
(
  input  logic       xb_illegal_csr,
  input  logic       fd_if_misalign,
  input  logic       fd_illegal,
  input  logic       fd_ld_misalign,
  input  logic       fd_st_misalign,
  input  logic       irq,
  output logic       valid,
  output logic [3:0] code
);

  always_comb begin
    valid = 1'b1;
    code  = CAUSE_ILLEGAL;
    if (xb_illegal_csr) begin
      code = CAUSE_ILLEGAL;
    end else if (fd_if_misalign) begin
      code = CAUSE_IF_MISALIGN;
    end else if (fd_illegal) begin
      code = CAUSE_ILLEGAL;
    end else if (fd_ld_misalign) begin
      code = CAUSE_LD_MISALIGN;
    end else if (fd_st_misalign) begin
      code = CAUSE_ST_MISALIGN;
    end else if (irq) begin
      code = CAUSE_M_EXT_IRQ;
    end else begin
      valid = 1'b0;
      code  = 4'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module      : trap_sequencer
// Description : Machine-mode trap entry / MRET return sequencer.
//               Optional external interrupt support under TRAP_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_sequencer
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_ADDR   = 32'h0000_0010,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetb,
  trap_sequencer_if.slave  bus
);

  localparam logic [3:0] c_drain_load = 4'(FLUSH_CYCLES);

  trap_state_e r_state;
  trap_state_e w_next;
  logic [3:0]  r_drain_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_tval;
  logic [3:0]  r_code;
  logic        w_irq;
  logic        w_valid;
  logic [3:0]  w_code;
  logic        w_stall;
  logic        w_flush;
  logic        w_we;
  logic        w_rvalid;
  logic [31:0] w_rpc;

`ifdef TRAP_IRQ_EN
  assign w_irq = bus.irq_ext & bus.mie_in;
`else
  assign w_irq = 1'b0;
`endif

  // A bubble's flags are dropped; the interrupt is independent of the slot.
  trap_cause_prio u_prio (
    .xb_illegal_csr (bus.xb_illegal_csr & ~bus.exc_bubble),
    .fd_if_misalign (bus.fd_if_misalign & ~bus.exc_bubble),
    .fd_illegal     (bus.fd_illegal     & ~bus.exc_bubble),
    .fd_ld_misalign (bus.fd_ld_misalign & ~bus.exc_bubble),
    .fd_st_misalign (bus.fd_st_misalign & ~bus.exc_bubble),
    .irq            (w_irq),
    .valid          (w_valid),
    .code           (w_code)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_drain_cnt <= 4'd0;
      r_pc        <= 32'd0;
      r_tval      <= 32'd0;
      r_code      <= 4'd0;
    end else begin
      if (r_state == ST_IDLE && w_valid) begin
        r_pc   <= bus.exc_pc;
        r_tval <= (w_code == CAUSE_M_EXT_IRQ) ? 32'd0 : bus.exc_tval;
        r_code <= w_code;
      end
      if (r_state == ST_CAPTURE) begin
        r_drain_cnt <= c_drain_load;
      end else if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_we     = 1'b0;
    w_rvalid = 1'b0;
    w_rpc    = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_next = ST_CAPTURE;
        end else if (bus.mret) begin
          w_next = ST_MRET_RET;
        end
      end
      ST_CAPTURE: begin
        w_flush = 1'b1;
        w_stall = 1'b1;
        w_next  = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_stall = 1'b1;
        if (r_drain_cnt <= 4'd1) begin
          w_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_next  = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        w_rvalid = 1'b1;
        w_rpc    = MTVEC_ADDR;
        w_next   = ST_IDLE;
      end
      ST_MRET_RET: begin
        w_flush  = 1'b1;
        w_rvalid = 1'b1;
        w_rpc    = bus.mepc_in;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.stall          = w_stall;
  assign bus.flush          = w_flush;
  assign bus.csr_trap_we    = w_we;
  assign bus.trap_taken     = w_we;
  assign bus.redirect_valid = w_rvalid;
  assign bus.redirect_pc    = w_rpc;
  assign bus.csr_mepc_wd    = r_pc;
  assign bus.csr_mcause_wd  = mcause_of(r_code);
  assign bus.csr_mtval_wd   = r_tval;

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Directed self-checking bench for trap_sequencer with a
//               scoreboard of expected CSR writes and fetch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_sequencer;

  typedef struct {
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } wr_t;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wr_seen = 0;
  int   n_rd_seen = 0;
  int   n_wr_exp  = 0;
  int   n_rd_exp  = 0;
  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];

  trap_sequencer_if bus ();

  trap_sequencer #(
    .MTVEC_ADDR   (32'h0000_0010),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.xb_illegal_csr = 1'b0;
    bus.fd_if_misalign = 1'b0;
    bus.fd_illegal     = 1'b0;
    bus.fd_ld_misalign = 1'b0;
    bus.fd_st_misalign = 1'b0;
    bus.exc_bubble     = 1'b0;
    bus.mret           = 1'b0;
`ifdef TRAP_IRQ_EN
    bus.irq_ext        = 1'b0;
    bus.mie_in         = 1'b0;
`endif
  endtask

  task automatic expect_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    wr_t w;
    w.mepc = pc; w.mcause = cause; w.mtval = tval;
    exp_wr_q.push_back(w);
    exp_rd_q.push_back(32'h0000_0010);
    n_wr_exp++;
    n_rd_exp++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {27'd0, bus.stall, bus.flush, bus.csr_trap_we,
                          bus.trap_taken, bus.redirect_valid}, 32'd0);
    check({tag, "_rpc"},    bus.redirect_pc,   32'd0);
    check({tag, "_mepc"},   bus.csr_mepc_wd,   32'd0);
    check({tag, "_mcause"}, bus.csr_mcause_wd, 32'd0);
    check({tag, "_mtval"},  bus.csr_mtval_wd,  32'd0);
  endtask

  // Scoreboard: every write strobe and redirect must match the next expected entry.
  always @(negedge clk) begin
    if (bus.csr_trap_we) begin
      n_wr_seen++;
      if (exp_wr_q.size() == 0) begin
        check("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_wr_q.pop_front();
        check("sb_mepc",   bus.csr_mepc_wd,   w.mepc);
        check("sb_mcause", bus.csr_mcause_wd, w.mcause);
        check("sb_mtval",  bus.csr_mtval_wd,  w.mtval);
        check("sb_taken",  {31'd0, bus.trap_taken}, 32'd1);
      end
    end
    if (bus.redirect_valid) begin
      n_rd_seen++;
      if (exp_rd_q.size() == 0) begin
        check("sb_unexpected_redirect", 32'd1, 32'd0);
      end else begin
        logic [31:0] r;
        r = exp_rd_q.pop_front();
        check("sb_redirect_pc", bus.redirect_pc, r);
      end
    end
  end

  initial begin
    clear_in();
    bus.exc_pc   = 32'd0;
    bus.exc_tval = 32'd0;
    bus.mepc_in  = 32'd0;
    tick();
    tick();
    check_all_zero("reset");
    resetb = 1'b1;
    tick();

    // 1: illegal instruction, full latency profile
    bus.fd_illegal = 1'b1; bus.exc_pc = 32'h100; bus.exc_tval = 32'h73;
    expect_trap(32'h100, 32'd2, 32'h73);
    tick();
    clear_in();
    check("t1_flush_T1", {30'd0, bus.flush, bus.stall}, 32'd3);
    tick();
    check("t1_T2", {29'd0, bus.stall, bus.flush, bus.csr_trap_we}, 32'd4);
    tick();
    check("t1_we_T3", {31'd0, bus.csr_trap_we}, 32'd0);
    tick();
    check("t1_we_T4", {30'd0, bus.csr_trap_we, bus.stall}, 32'd3);
    check("t1_mcause", bus.csr_mcause_wd, 32'd2);
    tick();
    check("t1_redir_T5", {31'd0, bus.redirect_valid}, 32'd1);
    check("t1_redir_pc", bus.redirect_pc, 32'h10);
    check("t1_stall_T5", {31'd0, bus.stall}, 32'd0);
    tick();
    check("t1_idle", {30'd0, bus.redirect_valid, bus.stall}, 32'd0);

    // 2: load+store misalign together; then bubble-masked flags
    bus.fd_ld_misalign = 1'b1; bus.fd_st_misalign = 1'b1;
    bus.exc_pc = 32'h300; bus.exc_tval = 32'h203;
    expect_trap(32'h300, 32'd4, 32'h203);
    tick();
    clear_in();
    repeat (5) tick();
    bus.fd_illegal = 1'b1; bus.xb_illegal_csr = 1'b1; bus.exc_bubble = 1'b1;
    tick();
    clear_in();
    check("t2_bubble", {30'd0, bus.flush, bus.stall}, 32'd0);
    repeat (4) tick();

    // 3: MRET return
    bus.mret = 1'b1; bus.mepc_in = 32'h240;
    exp_rd_q.push_back(32'h240);
    n_rd_exp++;
    tick();
    bus.mret = 1'b0;
    check("t3_mret", {29'd0, bus.flush, bus.redirect_valid, bus.csr_trap_we}, 32'd6);
    check("t3_mret_pc", bus.redirect_pc, 32'h240);
    tick();
    check("t3_idle", {30'd0, bus.flush, bus.redirect_valid}, 32'd0);

    // 4: exception beats MRET; late flag during DRAIN ignored
    bus.mret = 1'b1; bus.fd_if_misalign = 1'b1;
    bus.exc_pc = 32'h400; bus.exc_tval = 32'h402;
    expect_trap(32'h400, 32'd0, 32'h402);
    tick();
    clear_in();
    check("t4_capture", {30'd0, bus.flush, bus.redirect_valid}, 32'd2);
    tick();
    bus.fd_illegal = 1'b1; bus.exc_pc = 32'h500; bus.exc_tval = 32'h55;
    tick();
    clear_in();
    tick();
    check("t4_commit_mepc", bus.csr_mepc_wd, 32'h400);
    repeat (4) tick();

    // 5: reset during DRAIN aborts, then a fresh trap runs fully
    bus.fd_st_misalign = 1'b1; bus.exc_pc = 32'h600; bus.exc_tval = 32'h66;
    tick();
    clear_in();
    tick();
    resetb = 1'b0;
    #2;
    check_all_zero("t5_abort");
    tick();
    tick();
    resetb = 1'b1;
    tick();
    check("t5_after", {30'd0, bus.stall, bus.csr_trap_we}, 32'd0);
    bus.fd_ld_misalign = 1'b1; bus.exc_pc = 32'h700; bus.exc_tval = 32'h701;
    expect_trap(32'h700, 32'd4, 32'h701);
    tick();
    clear_in();
    check("t5_flush", {31'd0, bus.flush}, 32'd1);
    repeat (3) tick();
    check("t5_we", {31'd0, bus.csr_trap_we}, 32'd1);
    repeat (3) tick();

`ifdef TRAP_IRQ_EN
    // 6: external interrupt, then masked interrupt
    bus.irq_ext = 1'b1; bus.mie_in = 1'b1; bus.exc_pc = 32'h80; bus.exc_tval = 32'h1234;
    expect_trap(32'h80, 32'h8000_000B, 32'd0);
    tick();
    clear_in();
    check("t6_flush", {31'd0, bus.flush}, 32'd1);
    repeat (5) tick();
    bus.irq_ext = 1'b1; bus.mie_in = 1'b0;
    tick();
    clear_in();
    check("t6_masked", {30'd0, bus.flush, bus.stall}, 32'd0);
    repeat (4) tick();
`endif

    repeat (3) tick();
    check("end_wr_count", 32'(n_wr_seen), 32'(n_wr_exp));
    check("end_rd_count", 32'(n_rd_seen), 32'(n_rd_exp));
    check("end_wr_q", 32'(exp_wr_q.size()), 32'd0);
    check("end_rd_q", 32'(exp_rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
